// File: rtl/uci_msg_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uci_msg_serializer_pkg                                                     |
// | Shared constants, state encoding and helpers for the UCI serializer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uci_msg_serializer_pkg;

  localparam logic [7:0] c_newline    = 8'h0A;
  localparam int         c_prio_fixed = 0;
  localparam int         c_prio_rr    = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_NEWLINE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : uci_msg_serializer_pkg
`default_nettype wire

// File: rtl/uci_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uci_rr_arbiter                                                             |
// | One-hot request arbiter: fixed priority from channel 0, or round-robin     |
// | starting the search at the supplied pointer.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uci_rr_arbiter
  import uci_msg_serializer_pkg::*;
#(
  parameter int N_CH = 3,
  localparam int IW  = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic            rr_mode,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);

  // One spare bit so start + offset never wraps before the modulo fold.
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    w_sum     = '0;
    w_j       = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = (rr_mode ? {1'b0, ptr} : '0) + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N_CH)) begin
        w_sum = w_sum - (IW+1)'(N_CH);
      end
      w_j = w_sum[IW-1:0];
      if (!grant_vld && req[w_j]) begin
        grant_vld  = 1'b1;
        grant[w_j] = 1'b1;
        grant_idx  = w_j;
      end
    end
  end

endmodule : uci_rr_arbiter
`default_nettype wire

// File: rtl/uci_msg_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uci_msg_serializer                                                         |
// | Arbitrates N_CH message sources and streams the winner byte by byte,       |
// | optionally terminated by a newline character.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uci_msg_serializer
  import uci_msg_serializer_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int MAX_LEN   = 64,
  parameter int PRIO_MODE = 0,
  parameter int APPEND_NL = 1,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int IW = clog2_min1(N_CH),
  localparam int BW = clog2_min1(MAX_LEN)
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [N_CH-1:0][MAX_LEN-1:0][7:0]   msg_in,
  input  logic [N_CH-1:0][LW-1:0]             msg_len_in,
  input  logic [N_CH-1:0]                     msg_valid_in,
  output logic [N_CH-1:0]                     msg_ready_out,
  output logic [7:0]                          char_out,
  output logic                                char_out_valid,
  input  logic                                char_out_ready,
  output logic                                busy_out,
  output logic [IW-1:0]                       active_ch_out
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [MAX_LEN-1:0][7:0]  r_buf;
  logic [LW-1:0]            r_len;
  logic [BW-1:0]            r_idx;
  logic [IW-1:0]            r_ptr;
  logic [IW-1:0]            r_active;

  logic [N_CH-1:0]          w_grant;
  logic [IW-1:0]            w_grant_idx;
  logic                     w_grant_vld;
  logic [N_CH-1:0]          w_ready;
  logic                     w_accept;
  logic [LW-1:0]            w_sel_len;
  logic [LW-1:0]            w_cap_len;
  logic [IW-1:0]            w_ptr_nxt;
  logic                     w_last;

  uci_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req       (msg_valid_in),
    .rr_mode   (PRIO_MODE == c_prio_rr),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_vld (w_grant_vld)
  );

  assign w_ready   = (r_state == ST_IDLE) ? w_grant : '0;
  // The state register already clears asynchronously; gating here keeps the
  // handshake quiet for the whole reset interval, not just after the first edge.
  assign msg_ready_out = rst_n_in ? w_ready : '0;
  assign w_accept  = (r_state == ST_IDLE) && w_grant_vld;

  assign w_sel_len = msg_len_in[w_grant_idx];
  assign w_cap_len = (w_sel_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : w_sel_len;
  assign w_ptr_nxt = (w_grant_idx == IW'(N_CH - 1)) ? '0 : w_grant_idx + IW'(1);
  assign w_last    = (LW'(r_idx) + LW'(1)) == r_len;

  assign busy_out      = (r_state != ST_IDLE);
  assign active_ch_out = r_active;

  always_comb begin
    w_state_nxt    = r_state;
    char_out       = '0;
    char_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_cap_len != '0) begin
            w_state_nxt = ST_SEND;
          end else if (APPEND_NL != 0) begin
            w_state_nxt = ST_NEWLINE;
          end
        end
      end
      ST_SEND: begin
        char_out       = r_buf[r_idx];
        char_out_valid = 1'b1;
        if (char_out_ready && w_last) begin
          w_state_nxt = (APPEND_NL != 0) ? ST_NEWLINE : ST_IDLE;
        end
      end
      ST_NEWLINE: begin
        char_out       = c_newline;
        char_out_valid = 1'b1;
        if (char_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_active <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_len    <= w_cap_len;
        r_idx    <= '0;
        r_active <= w_grant_idx;
        r_ptr    <= w_ptr_nxt;
      end else if (r_state == ST_SEND && char_out_ready) begin
        r_idx <= w_last ? '0 : r_idx + BW'(1);
      end
    end
  end

  // Payload storage needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_buf <= msg_in[w_grant_idx];
    end
  end

endmodule : uci_msg_serializer
`default_nettype wire

// File: tb/tb_uci_msg_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uci_msg_serializer                                                      |
// | Two serializer instances (round-robin + newline, fixed + no newline)       |
// | against a queue-based reference model and scoreboard monitor.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uci_msg_serializer;
  import uci_msg_serializer_pkg::*;

  localparam int N_CH    = 3;
  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int IW      = 2;
  localparam int N_DUT   = 2;
  localparam int LIMIT   = 2000;

  typedef struct {
    logic [MAX_LEN-1:0][7:0] data;
    int                      len;
  } msg_t;
  typedef struct { logic [7:0] ch; bit last; } exp_char_t;
  typedef struct { int ch; bit has_out; } exp_grant_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_CH-1:0][MAX_LEN-1:0][7:0] msg_in    [N_DUT];
  logic [N_CH-1:0][LW-1:0]           msg_len   [N_DUT];
  logic [N_CH-1:0]                   msg_valid [N_DUT];
  logic [N_CH-1:0]                   msg_ready [N_DUT];
  logic [7:0]                        char_o    [N_DUT];
  logic                              char_v    [N_DUT];
  logic                              char_rdy  [N_DUT];
  logic                              busy      [N_DUT];
  logic [IW-1:0]                     act       [N_DUT];

  exp_char_t  exp_c [N_DUT][$];
  exp_grant_t exp_g [N_DUT][$];
  msg_t       pend  [N_DUT][N_CH][$];
  msg_t       stage [N_DUT][N_CH][$];
  int         model_ptr [N_DUT];
  int         rdy_mode  [N_DUT];
  int         hs_cnt    [N_DUT];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uci_msg_serializer #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .PRIO_MODE(1), .APPEND_NL(1)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .msg_in(msg_in[0]), .msg_len_in(msg_len[0]),
    .msg_valid_in(msg_valid[0]), .msg_ready_out(msg_ready[0]), .char_out(char_o[0]),
    .char_out_valid(char_v[0]), .char_out_ready(char_rdy[0]), .busy_out(busy[0]),
    .active_ch_out(act[0]));

  uci_msg_serializer #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .PRIO_MODE(0), .APPEND_NL(0)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .msg_in(msg_in[1]), .msg_len_in(msg_len[1]),
    .msg_valid_in(msg_valid[1]), .msg_ready_out(msg_ready[1]), .char_out(char_o[1]),
    .char_out_valid(char_v[1]), .char_out_ready(char_rdy[1]), .busy_out(busy[1]),
    .active_ch_out(act[1]));

  function automatic bit is_rr(input int d);
    return d == 0;
  endfunction

  function automatic bit has_nl(input int d);
    return d == 0;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, want, $time);
    end
  endtask

  function automatic msg_t str_msg(input string s);
    msg_t m;
    m.data = '0;
    for (int i = 0; i < s.len() && i < MAX_LEN; i++) m.data[i] = s[i];
    m.len = s.len();
    return m;
  endfunction

  function automatic msg_t rand_msg(input int len);
    msg_t m;
    for (int i = 0; i < MAX_LEN; i++) m.data[i] = 8'($urandom);
    m.len = len;
    return m;
  endfunction

  // Reference model: replay the arbitration over the staged messages (each
  // source re-offers until its queue is empty) and list the expected stream.
  task automatic commit(input int d);
    int rem [N_CH];
    int pos [N_CH];
    int total, g, c, eff;
    msg_t m;
    total = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      rem[ch] = stage[d][ch].size();
      pos[ch] = 0;
      total += rem[ch];
    end
    while (total > 0) begin
      g = -1;
      for (int k = 0; k < N_CH; k++) begin
        c = is_rr(d) ? (model_ptr[d] + k) % N_CH : k;
        if (g < 0 && rem[c] > 0) g = c;
      end
      m = stage[d][g][pos[g]];
      pos[g]++;
      rem[g]--;
      total--;
      model_ptr[d] = (g + 1) % N_CH;
      eff = (m.len > MAX_LEN) ? MAX_LEN : m.len;
      exp_g[d].push_back('{ch: g, has_out: (eff > 0) || has_nl(d)});
      for (int i = 0; i < eff; i++)
        exp_c[d].push_back('{ch: m.data[i], last: !has_nl(d) && (i == eff - 1)});
      if (has_nl(d)) exp_c[d].push_back('{ch: 8'h0A, last: 1'b1});
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      foreach (stage[d][ch][i]) pend[d][ch].push_back(stage[d][ch][i]);
      stage[d][ch].delete();
    end
  endtask

  function automatic int pend_cnt(input int d);
    int n = 0;
    for (int ch = 0; ch < N_CH; ch++) n += pend[d][ch].size();
    return n;
  endfunction

  task automatic wait_done(input int d);
    int n = 0;
    while ((pend_cnt(d) > 0 || exp_c[d].size() > 0 || exp_g[d].size() > 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("round_completes_in_budget", d, 32'(n < LIMIT), 1);
    if (n >= LIMIT) begin
      exp_c[d].delete();
      exp_g[d].delete();
      for (int ch = 0; ch < N_CH; ch++) pend[d][ch].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_round(input int d);
    int n, len;
    for (int ch = 0; ch < N_CH; ch++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        len = ($urandom_range(0, 9) == 0) ? MAX_LEN + $urandom_range(1, 5) : $urandom_range(0, MAX_LEN);
        stage[d][ch].push_back(rand_msg(len));
      end
    end
    rdy_mode[d] = $urandom_range(0, 2);
    commit(d);
    wait_done(d);
  endtask

  // Source driver: presents the head of each channel queue, pops on handshake.
  initial begin : src_drv
    logic [N_CH-1:0] acc [N_DUT];
    for (int d = 0; d < N_DUT; d++) begin
      msg_valid[d] = '0;
      msg_in[d]    = '0;
      msg_len[d]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < N_DUT; d++) acc[d] = rst_n ? (msg_valid[d] & msg_ready[d]) : '0;
      @(posedge clk);
      #1;
      for (int d = 0; d < N_DUT; d++) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (acc[d][ch] && pend[d][ch].size() > 0) void'(pend[d][ch].pop_front());
          if (pend[d][ch].size() > 0) begin
            msg_in[d][ch]    = pend[d][ch][0].data;
            msg_len[d][ch]   = LW'(pend[d][ch][0].len);
            msg_valid[d][ch] = 1'b1;
          end else begin
            for (int i = 0; i < MAX_LEN; i++) msg_in[d][ch][i] = 8'($urandom);
            msg_len[d][ch]   = LW'($urandom);
            msg_valid[d][ch] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    int cyc = 0;
    for (int d = 0; d < N_DUT; d++) char_rdy[d] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < N_DUT; d++) begin
        case (rdy_mode[d])
          0:       char_rdy[d] = 1'b1;
          1:       char_rdy[d] = (cyc % 3 == 0);
          default: char_rdy[d] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard whenever a DUT presents a handshake.
  initial begin : monitor
    bit              stall_v   [N_DUT];
    logic [7:0]      stall_c   [N_DUT];
    bit              first_chk [N_DUT];
    bit              first_exp [N_DUT];
    bit              gap_chk   [N_DUT];
    int              act_exp   [N_DUT];
    logic [N_CH-1:0] acc;
    exp_grant_t      eg;
    exp_char_t       ec;
    for (int d = 0; d < N_DUT; d++) begin
      stall_v[d] = 0; first_chk[d] = 0; gap_chk[d] = 0; act_exp[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < N_DUT; d++) begin
        if (!rst_n) begin
          stall_v[d] = 0; first_chk[d] = 0; gap_chk[d] = 0; act_exp[d] = 0;
          continue;
        end
        if (first_chk[d]) begin
          chk("first_char_after_accept", d, 32'(char_v[d]), 32'(first_exp[d]));
          chk("busy_after_accept", d, 32'(busy[d]), 32'(first_exp[d]));
          first_chk[d] = 0;
        end
        if (gap_chk[d]) begin
          chk("idle_gap_valid_low", d, 32'(char_v[d]), 0);
          gap_chk[d] = 0;
        end
        if (stall_v[d]) begin
          chk("stall_valid_held", d, 32'(char_v[d]), 1);
          chk("stall_char_stable", d, 32'(char_o[d]), 32'(stall_c[d]));
        end
        acc = msg_valid[d] & msg_ready[d];
        if (msg_ready[d] != '0) chk("ready_subset_of_valid", d, 32'(msg_ready[d] & ~msg_valid[d]), 0);
        if (acc != '0) begin
          chk("grant_onehot", d, 32'($onehot(acc)), 1);
          if (exp_g[d].size() == 0) begin
            chk("grant_not_expected", d, 32'(acc), 0);
          end else begin
            eg = exp_g[d].pop_front();
            chk("grant_channel", d, 32'(acc), 32'(1 << eg.ch));
            act_exp[d]   = eg.ch;
            first_chk[d] = 1;
            first_exp[d] = eg.has_out;
          end
        end
        if (char_v[d]) chk("active_ch", d, 32'(act[d]), 32'(act_exp[d]));
        if (char_v[d] && char_rdy[d]) begin
          hs_cnt[d]++;
          if (exp_c[d].size() == 0) begin
            chk("char_not_expected", d, 32'(char_o[d]), 32'hFFFF);
          end else begin
            ec = exp_c[d].pop_front();
            chk("char_value", d, 32'(char_o[d]), 32'(ec.ch));
            if (ec.last) gap_chk[d] = 1;
          end
        end
        stall_v[d] = char_v[d] && !char_rdy[d];
        stall_c[d] = char_o[d];
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base, n;
    rst_n = 1'b0;
    for (int d = 0; d < N_DUT; d++) begin
      model_ptr[d] = 0; rdy_mode[d] = 0; hs_cnt[d] = 0;
    end
    // Offer a message while reset is held: it must not be taken until release.
    stage[0][0].push_back(str_msg("id name River"));
    commit(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      chk("reset_char_valid", d, 32'(char_v[d]), 0);
      chk("reset_char_out", d, 32'(char_o[d]), 0);
      chk("reset_busy", d, 32'(busy[d]), 0);
      chk("reset_active_ch", d, 32'(act[d]), 0);
    end
    chk("reset_ready_with_valid", 0, 32'(msg_ready[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_done(0);

    rdy_mode[0] = 1;
    stage[0][1].push_back(str_msg("bestmove e2e4"));
    commit(0);
    wait_done(0);

    rdy_mode[0] = 2;
    stage[0][2].push_back(rand_msg(0));
    stage[0][1].push_back(rand_msg(MAX_LEN + 5));
    commit(0);
    wait_done(0);

    // Abort a message after its fourth byte.
    rdy_mode[0] = 0;
    stage[0][1].push_back(rand_msg(10));
    commit(0);
    base = hs_cnt[0];
    n = 0;
    while (hs_cnt[0] < base + 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("reached_byte4_before_reset", 0, 32'(n < LIMIT), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid_drop", 0, 32'(char_v[0]), 0);
    chk("async_reset_char_out", 0, 32'(char_o[0]), 0);
    chk("async_reset_busy", 0, 32'(busy[0]), 0);
    chk("async_reset_active_ch", 0, 32'(act[0]), 0);
    for (int d = 0; d < N_DUT; d++) begin
      exp_c[d].delete();
      exp_g[d].delete();
      for (int ch = 0; ch < N_CH; ch++) pend[d][ch].delete();
      model_ptr[d] = 0;
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // All three sources busy, two-byte messages: grants 0,1,2,0 from a fresh pointer.
    stage[0][0].push_back(rand_msg(2));
    stage[0][0].push_back(rand_msg(2));
    stage[0][1].push_back(rand_msg(2));
    stage[0][2].push_back(rand_msg(2));
    commit(0);
    wait_done(0);

    for (int r = 0; r < 6; r++) rand_round(0);

    rdy_mode[1] = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      stage[1][ch].push_back(rand_msg(2));
      if (ch < 2) stage[1][ch].push_back(rand_msg(2));
    end
    commit(1);
    wait_done(1);

    stage[1][1].push_back(rand_msg(0));
    commit(1);
    wait_done(1);

    for (int r = 0; r < 6; r++) rand_round(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uci_msg_serializer
`default_nettype wire
